// File: rtl/serial_frame_arbiter_pkg.sv
// Shared types and default parameter values for the serial frame arbiter.
// The frame FSM state encoding lives here so every file agrees on it.
package serial_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    GAP
  } state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int GAP_CNT_W      = 4;

endpackage

// File: rtl/serial_frame_arbiter_if.sv
// Request/data bus between the requesters (master) and the serial frame arbiter (slave).
// Widths follow the arbiter's N_REQ and WIDTH parameters.
interface serial_frame_arbiter_if
  import serial_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);

  logic [N_REQ-1:0]         i_req;
  logic [N_REQ*WIDTH-1:0]   i_data;
  logic [N_REQ-1:0]         o_ack;
  logic [$clog2(N_REQ)-1:0] o_src;
  logic                     o_busy;
  logic                     o_serial_data;
  logic                     o_latch;

  modport master (
    output i_req, i_data,
    input  o_ack, o_src, o_busy, o_serial_data, o_latch
  );

  modport slave (
    input  i_req, i_data,
    output o_ack, o_src, o_busy, o_serial_data, o_latch
  );

endinterface

// File: rtl/serial_frame_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first requester at or after last_grant+1.
// Only the last_grant register is sequential; the selection itself is combinational.
module rr_arbiter
  import serial_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic                     o_serial_clk,
  input  logic                     i_reset_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic                     i_update,
  output logic [$clog2(N_REQ)-1:0] o_grant,
  output logic                     o_valid
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] r_last_grant;

  // Reset to the highest index so requester 0 wins the first arbitration.
  always_ff @(posedge o_serial_clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!i_reset_n) begin
      r_last_grant <= IDX_W'(N_REQ - 1);
    end else if (i_update) begin
      r_last_grant <= o_grant;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the loop leaves an output unassigned (no latch).
    o_grant = '0;
    o_valid = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!o_valid && i_req[IDX_W'((int'(r_last_grant) + i) % N_REQ)]) begin
        o_valid = 1'b1;
        o_grant = IDX_W'((int'(r_last_grant) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/serial_frame_arbiter.sv
// Serialises one requester's word per frame, MSB first, followed by a latch pulse and an idle gap.
// Requesters are served round-robin; the frame is IDLE -> SHIFT -> LATCH -> GAP -> IDLE.
module serial_frame_arbiter
  import serial_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                  o_serial_clk,
  input  logic                  i_reset_n,
  serial_frame_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [GAP_CNT_W-1:0] r_gap_cnt;
  logic [N_REQ-1:0]   r_ack;
  logic [IDX_W-1:0]   r_src;

  logic [IDX_W-1:0]   w_grant;
  logic               w_valid;
  logic               w_capture;
  logic               w_busy;
  logic               w_serial_data;
  logic               w_latch;

  assign w_capture = (r_state == IDLE) && w_valid;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .o_serial_clk (o_serial_clk),
    .i_reset_n    (i_reset_n),
    .i_req        (bus.i_req),
    .i_update     (w_capture),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  always_ff @(posedge o_serial_clk) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_busy        = 1'b1;
    w_serial_data = 1'b0;
    w_latch       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_valid) w_next_state = SHIFT;
      end
      SHIFT: begin
        w_serial_data = r_shift[WIDTH-1];
        if (r_bit_cnt == '0) w_next_state = LATCH;
      end
      LATCH: begin
        w_latch      = 1'b1;
        w_next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        // The counter holds the number of gap cycles still to run, this one included.
        if (r_gap_cnt <= GAP_CNT_W'(1)) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge o_serial_clk) begin
    if (!i_reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_ack     <= '0;
      r_src     <= '0;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_shift   <= bus.i_data[w_grant*WIDTH +: WIDTH];
            r_src     <= w_grant;
            r_bit_cnt <= CNT_W'(WIDTH - 1);
            r_ack     <= N_REQ'(1) << w_grant;
          end
        end
        SHIFT: begin
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - CNT_W'(1);
        end
        LATCH: begin
          r_gap_cnt <= GAP_CNT_W'(GAP_CYCLES);
        end
        GAP: begin
          if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GAP_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ack         = r_ack;
  assign bus.o_src         = r_src;
  assign bus.o_busy        = w_busy;
  assign bus.o_serial_data = w_serial_data;
  assign bus.o_latch       = w_latch;

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Self-checking bench: directed scenarios on a GAP=2 instance and a random
// shift-in scoreboard on a GAP=0 instance, both N_REQ=4, WIDTH=8.
module tb_serial_frame_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc   = 0;
  int     n_checks = 0;
  int     n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus_a ();
  serial_frame_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus_b ();

  serial_frame_arbiter #(.N_REQ(N), .WIDTH(W), .GAP_CYCLES(2)) dut_a (
    .o_serial_clk (clk),
    .i_reset_n    (rst_n),
    .bus          (bus_a)
  );

  serial_frame_arbiter #(.N_REQ(N), .WIDTH(W), .GAP_CYCLES(0)) dut_b (
    .o_serial_clk (clk),
    .i_reset_n    (rst_n),
    .bus          (bus_b)
  );

  typedef struct {
    bit         found;
    int         wait_cyc;
    logic [3:0] ack;
    logic [1:0] src;
    logic [7:0] word;
    int         latch_off;
    int         busy_off;
    bit         stray;
    longint     t_ack;
  } frame_t;

  // Reference round-robin choice: first requester after 'last', wrapping.
  function automatic int rr_pick(input int last, input logic [3:0] req);
    for (int s = 1; s <= N; s++) begin
      int k;
      k = (last + s) % N;
      if (((req >> k) & 4'd1) != 4'd0) return k;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_a.i_req = '0;
    bus_b.i_req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Watches one frame on instance A; offsets are counted from the ack cycle.
  task automatic observe_a(output frame_t f);
    int off;
    f.found = 0; f.wait_cyc = 0; f.ack = '0; f.src = '0; f.word = '0;
    f.latch_off = -1; f.busy_off = -1; f.stray = 0; f.t_ack = 0;
    for (int i = 0; i < 40 && !f.found; i++) begin
      @(negedge clk);
      f.wait_cyc++;
      if (bus_a.o_ack != 4'b0) f.found = 1;
    end
    if (!f.found) return;
    f.ack     = bus_a.o_ack;
    f.src     = bus_a.o_src;
    f.t_ack   = cyc;
    f.word[7] = bus_a.o_serial_data;
    for (int b = 6; b >= 0; b--) begin
      @(negedge clk);
      f.word[b] = bus_a.o_serial_data;
      if (bus_a.o_ack != 4'b0 || bus_a.o_latch || !bus_a.o_busy) f.stray = 1;
    end
    off = 7;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      off++;
      if (bus_a.o_latch && f.latch_off < 0) f.latch_off = off;
      if (bus_a.o_serial_data || bus_a.o_ack != 4'b0) f.stray = 1;
      if (!bus_a.o_busy) begin
        f.busy_off = off;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_a.i_req = '0; bus_a.i_data = '0;
    bus_b.i_req = '0; bus_b.i_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus_a.o_ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", bus_a.o_ack); end
    n_checks++; if (bus_a.o_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", bus_a.o_src); end
    n_checks++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_a.o_busy); end
    n_checks++; if (bus_a.o_serial_data !== 1'b0) begin n_fail++; $display("FAIL reset_serial: got %b want 0", bus_a.o_serial_data); end
    n_checks++; if (bus_a.o_latch !== 1'b0) begin n_fail++; $display("FAIL reset_latch: got %b want 0", bus_a.o_latch); end
    n_checks++; if (bus_b.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", bus_b.o_busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    frame_t f;
    do_reset();
    bus_a.i_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'hA5};
    bus_a.i_req  = 4'b0001;
    observe_a(f);
    bus_a.i_req  = 4'b0000;
    n_checks++; if (!f.found) begin n_fail++; $display("FAIL single_timeout: no ack within bound"); end
    n_checks++; if (f.wait_cyc != 1) begin n_fail++; $display("FAIL single_latency: ack after %0d cycles want 1", f.wait_cyc); end
    n_checks++; if (f.ack !== 4'(1) << rr_pick(N - 1, 4'b0001)) begin n_fail++; $display("FAIL single_ack: got %b want 0001", f.ack); end
    n_checks++; if (f.src !== 2'd0) begin n_fail++; $display("FAIL single_src: got %0d want 0", f.src); end
    n_checks++; if (f.word !== 8'hA5) begin n_fail++; $display("FAIL single_bits: got %h want a5", f.word); end
    n_checks++; if (f.latch_off != W) begin n_fail++; $display("FAIL single_latch_pos: got %0d want %0d", f.latch_off, W); end
    n_checks++; if (f.busy_off - f.latch_off != 2 + 1) begin n_fail++; $display("FAIL single_gap: busy low %0d after latch want 3", f.busy_off - f.latch_off); end
    n_checks++; if (f.stray) begin n_fail++; $display("FAIL single_stray: unexpected ack/latch/data during frame"); end
  endtask

  task automatic test_fairness();
    frame_t f;
    logic [7:0] words [4];
    int last;
    longint prev_t;
    int exp;
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    bus_a.i_data = {words[3], words[2], words[1], words[0]};
    bus_a.i_req  = 4'b1111;
    last   = N - 1;
    prev_t = 0;
    for (int fr = 0; fr < 5; fr++) begin
      observe_a(f);
      exp = rr_pick(last, 4'b1111);
      n_checks++; if (f.ack !== 4'(1) << exp) begin n_fail++; $display("FAIL fair_ack[%0d]: got %b want idx %0d", fr, f.ack, exp); end
      n_checks++; if (f.word !== words[exp]) begin n_fail++; $display("FAIL fair_word[%0d]: got %h want %h", fr, f.word, words[exp]); end
      if (fr > 0) begin
        n_checks++; if (f.t_ack - prev_t != longint'(W + 1 + 2 + 1)) begin n_fail++; $display("FAIL fair_period[%0d]: got %0d want %0d", fr, f.t_ack - prev_t, W + 4); end
      end
      prev_t = f.t_ack;
      last   = exp;
    end
    bus_a.i_req = 4'b0000;
  endtask

  task automatic test_skip_idle();
    frame_t f;
    int exp;
    do_reset();
    bus_a.i_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    bus_a.i_req  = 4'b0010;
    observe_a(f);
    n_checks++; if (f.ack !== 4'b0010) begin n_fail++; $display("FAIL skip_first_ack: got %b want 0010", f.ack); end
    bus_a.i_req = 4'b0011;
    observe_a(f);
    bus_a.i_req = 4'b0000;
    exp = rr_pick(1, 4'b0011);
    n_checks++; if (f.ack !== 4'(1) << exp) begin n_fail++; $display("FAIL skip_rotate_ack: got %b want idx %0d", f.ack, exp); end
    n_checks++; if (f.word !== bus_a.i_data[exp*W +: W]) begin n_fail++; $display("FAIL skip_rotate_word: got %h want %h", f.word, bus_a.i_data[exp*W +: W]); end
  endtask

  task automatic test_reset_mid_frame();
    frame_t f;
    logic [7:0] w2;
    bit got_ack;
    bit saw_latch;
    do_reset();
    w2 = 8'($urandom);
    bus_a.i_data = {8'($urandom), w2, 8'($urandom), 8'($urandom)};
    bus_a.i_req  = 4'b0100;
    got_ack = 0;
    for (int i = 0; i < 10 && !got_ack; i++) begin
      @(negedge clk);
      if (bus_a.o_ack != 4'b0) got_ack = 1;
    end
    n_checks++; if (!got_ack) begin n_fail++; $display("FAIL midrst_first_ack: no ack within bound"); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    saw_latch = 0;
    @(negedge clk);
    n_checks++; if ({bus_a.o_ack, bus_a.o_src, bus_a.o_busy, bus_a.o_serial_data, bus_a.o_latch} !== 9'b0)
      begin n_fail++; $display("FAIL midrst_outputs: ack=%b src=%0d busy=%b ser=%b latch=%b want all 0",
        bus_a.o_ack, bus_a.o_src, bus_a.o_busy, bus_a.o_serial_data, bus_a.o_latch); end
    repeat (2) begin
      @(negedge clk);
      if (bus_a.o_latch) saw_latch = 1;
    end
    n_checks++; if (saw_latch) begin n_fail++; $display("FAIL midrst_latch: latch pulsed during reset, want none"); end
    rst_n = 1'b1;
    observe_a(f);
    bus_a.i_req = 4'b0000;
    n_checks++; if (f.wait_cyc != 1) begin n_fail++; $display("FAIL midrst_release_latency: got %0d want 1", f.wait_cyc); end
    n_checks++; if (f.ack !== 4'b0100) begin n_fail++; $display("FAIL midrst_regrant: got %b want 0100", f.ack); end
    n_checks++; if (f.word !== w2) begin n_fail++; $display("FAIL midrst_word: got %h want %h", f.word, w2); end
    n_checks++; if (f.latch_off != W) begin n_fail++; $display("FAIL midrst_latch_pos: got %0d want %0d", f.latch_off, W); end
  endtask

  task automatic test_withdrawal();
    bit saw_ack;
    do_reset();
    bus_a.i_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    bus_a.i_req  = 4'b0011;
    @(negedge clk);
    n_checks++; if (bus_a.o_ack !== 4'b0001) begin n_fail++; $display("FAIL withdraw_first_ack: got %b want 0001", bus_a.o_ack); end
    bus_a.i_req = 4'b0000;
    saw_ack = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_a.o_ack != 4'b0) saw_ack = 1;
    end
    n_checks++; if (saw_ack) begin n_fail++; $display("FAIL withdraw_ack: ack seen for withdrawn requester"); end
    n_checks++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL withdraw_idle: busy=%b want 0", bus_a.o_busy); end
  endtask

  // Random requesters on the GAP=0 instance; the serial line is shifted in on
  // falling edges and compared at each latch pulse against the acknowledged word.
  task automatic test_scoreboard();
    logic [3:0] req;
    logic [7:0] words [4];
    logic [7:0] sr;
    logic [7:0] exp_q [$];
    logic [7:0] exp_w;
    int last, frames, budget, exp;
    do_reset();
    req = '0; sr = '0; last = N - 1; frames = 0; budget = 0;
    for (int k = 0; k < N; k++) words[k] = '0;
    while (frames < 1000 && budget < 40000) begin
      @(negedge clk);
      budget++;
      if (bus_b.o_latch) begin
        frames++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++; if (sr !== exp_w) begin n_fail++; $display("FAIL sb_word[%0d]: got %h want %h", frames, sr, exp_w); end
      end
      sr = {sr[6:0], bus_b.o_serial_data};
      if (bus_b.o_ack != 4'b0) begin
        exp = rr_pick(last, req);
        n_checks++; if (exp < 0 || bus_b.o_ack !== 4'(1) << exp) begin n_fail++; $display("FAIL sb_grant: got %b want idx %0d (req %b)", bus_b.o_ack, exp, req); end
        if (exp >= 0) begin
          exp_q.push_back(words[exp]);
          last = exp;
        end
        req = req & ~bus_b.o_ack;
      end
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(0, 3) == 0) begin
          words[k] = 8'($urandom);
          req[k]   = 1'b1;
        end
      end
      bus_b.i_req  = req;
      bus_b.i_data = {words[3], words[2], words[1], words[0]};
    end
    bus_b.i_req = '0;
    n_checks++; if (frames != 1000) begin n_fail++; $display("FAIL sb_timeout: got %0d frames want 1000", frames); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d acked words never latched, want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_skip_idle();
    test_reset_mid_frame();
    test_withdrawal();
    test_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
